uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each byte the receiver presents with its one-cycle done strobe and stores it in a first-word-fall-through FIFO. It presents the bytes to the consuming logic (command parser, bus bridge) over a valid/ready handshake. Overrun is never silent: a byte arriving while the FIFO is full is dropped and a sticky error flag is raised.

## Interface
- DEPTH, 16: number of byte slots; power of two, minimum 2.
- WIDTH, 8: data width in bits; matches the receiver byte.
- AFULL_THRESH, 12: almost-full level; present only with UART_RX_FIFO_LEVEL_EN; 1 ≤ value ≤ DEPTH.
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_data  in  WIDTH  received byte; sampled only when in_valid=1.
- in_valid  in  1  one-cycle strobe from the receiver's done output.
- out_data  out  WIDTH  head-of-FIFO byte; meaningful only when out_valid=1.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head; a pop occurs when out_valid&&out_ready.
- full  out  1  all DEPTH slots occupied.
- overflow  out  1  sticky; a byte was dropped.
- overflow_clr  in  1  single-cycle clear of overflow.
- level  out  log2(DEPTH)+1  occupancy, 0..DEPTH; present only with UART_RX_FIFO_LEVEL_EN.
- almost_full  out  1  level ≥ AFULL_THRESH; present only with UART_RX_FIFO_LEVEL_EN.

## Operation
- Storage: DEPTH×WIDTH array, write pointer wr_ptr and read pointer rd_ptr, each log2(DEPTH)+1 bits. The extra MSB distinguishes full from empty.
- Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ.
- Push = in_valid && (!full || pop). On push, mem[wr_ptr] ← in_data and wr_ptr increments.
- Pop = out_valid && out_ready. On pop, rd_ptr increments.
- Pointers wrap modulo 2·DEPTH naturally. No explicit wrap compare.
- out_data = mem[rd_ptr low bits], read combinationally (FWFT).
- out_valid = !empty, driven from pointer registers only.
- Full with simultaneous push and pop: both are accepted and occupancy is unchanged.
- Empty with simultaneous push and pop: the pop cannot happen because out_valid=0. The push is accepted.
- Overflow: when in_valid && full && !pop, the byte is discarded and overflow is set. Pointers and contents are unchanged.
- overflow_clr clears overflow. If the clear and a new drop occur in the same cycle, the set wins.
- in_valid held high for several cycles is treated as several pushes. The receiver guarantees one-cycle strobes; the FIFO does not deduplicate.
- Reset (async, any time, mid-transfer included): both pointers 0, overflow 0. Contents are discarded but the array itself is not cleared.

## Timing
- Reset values: out_valid 0, full 0, overflow 0, level 0, almost_full 0. out_data is don't-care.
- Latency: push at edge N into an empty FIFO gives out_valid=1 and out_data valid after edge N (one cycle).
- Pop at edge N: the next byte is on out_data after edge N. out_valid drops after edge N if that was the last byte.
- full, level and almost_full are registered-pointer derived and update after the edge that changes the pointers.
- Sustained throughput: one push and one pop per cycle.
- rst_n deassertion must be synchronised to clk externally; the block assumes a clean release.

## Configuration
- UART_RX_FIFO_LEVEL_EN defined:
  - The AFULL_THRESH parameter and the level and almost_full ports exist.
  - level = wr_ptr − rd_ptr, computed modulo 2·DEPTH at pointer width.
  - almost_full is compared against AFULL_THRESH. It is intended for RTS-style flow control toward the remote transmitter.
- UART_RX_FIFO_LEVEL_EN undefined: the parameter, both ports and the subtractor are absent. All other behaviour is identical.

## Structure
- Shared package uart_pkg:
  - UART_DATA_W = 8.
  - Default FIFO depth constant.
  - A byte typedef shared by the receiver, this FIFO and the transmit path.
- Sub-module uart_fifo_mem: DEPTH×WIDTH array with one synchronous write port and one asynchronous read port. It is reused by the future transmit FIFO.
- Pointer logic, flag logic and the overflow register stay in uart_rx_fifo.

## Test plan
- Reset, then push 0xA5 with out_ready=0:
  - out_valid=1 and out_data=0xA5 one cycle later.
  - full=0; level=1 when the macro is defined.
- Push 0x00..0x0F (DEPTH=16) with out_ready=0:
  - full=1 after the 16th push.
  - Push 0xFF: overflow=1, and draining yields exactly 0x00..0x0F in order.
- FIFO full, then in_valid and out_ready in the same cycle with in_data=0x55:
  - 0x00 is popped and 0x55 is accepted.
  - full stays 1 and no overflow is raised.
- Continuous push/pop for 40 bytes with out_ready=1:
  - The output sequence equals the input sequence, one cycle behind.
  - Pointers wrap at least twice; empty/full never glitch.
- Overflow flag:
  - Set overflow, then assert overflow_clr in the same cycle as another drop: overflow stays 1.
  - Assert overflow_clr alone next cycle: overflow clears to 0.
- Load 5 bytes, then assert rst_n=0 asynchronously between edges:
  - out_valid=0 and full=0 immediately; level=0 when the macro is defined.
  - After release, a push of 0x3C appears as the first output.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, default FIFO depth and the byte type.
// Used by the receiver, the receive FIFO and the transmit path.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte-stream bundle between the UART receiver, the receive FIFO and its consumer.
// level/almost_full exist only when UART_RX_FIFO_LEVEL_EN is defined.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             full;
  logic             overflow;
  logic             overflow_clr;
`ifdef UART_RX_FIFO_LEVEL_EN
  logic [LW-1:0]    level;
  logic             almost_full;
`endif

  // master is the FIFO itself; slave is the receiver/consumer side
  modport master (
    input  in_data, in_valid, out_ready, overflow_clr,
`ifdef UART_RX_FIFO_LEVEL_EN
    output level, almost_full,
`endif
    output out_data, out_valid, full, overflow
  );

  modport slave (
    output in_data, in_valid, out_ready, overflow_clr,
`ifdef UART_RX_FIFO_LEVEL_EN
    input  level, almost_full,
`endif
    input  out_data, out_valid, full, overflow
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// Write lands on the clock edge; read is combinational. No flow control here.
// Contents are not reset; the pointer owner decides what is valid.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO (first-word-fall-through) behind the UART receiver; optional level via UART_RX_FIFO_LEVEL_EN.
// Latency: a push is visible on out_data/out_valid one cycle later; one push and one pop per cycle sustained.
// Backpressure: out_ready stalls the head; the receiver cannot be stalled, so a byte arriving while full is dropped and sets sticky overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int WIDTH = UART_DATA_W
`ifdef UART_RX_FIFO_LEVEL_EN
  ,
  parameter int AFULL_THRESH = 12
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_fifo_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          overflow_q;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;

  // Extra pointer MSB separates full (laps differ) from empty (laps equal)
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees a slot this cycle, so a full FIFO may still accept a push
  assign pop  = !empty && bus.out_ready;
  assign push = bus.in_valid && (!full || pop);
  assign drop = bus.in_valid && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // A drop in the same cycle as a clear must leave the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (bus.overflow_clr) begin
      overflow_q <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (bus.in_data),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (bus.out_data)
  );

  assign bus.out_valid = !empty;
  assign bus.full      = full;
  assign bus.overflow  = overflow_q;

`ifdef UART_RX_FIFO_LEVEL_EN
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [PW-1:0] level;

  // Modulo-2*DEPTH difference gives 0..DEPTH with no wrap compare
  assign level           = wr_ptr - rd_ptr;
  assign bus.level       = level;
  assign bus.almost_full = (level >= AFULL_LVL);
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and random stimulus for uart_rx_fifo, checked against a queue model of a byte FIFO.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int AFULL = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         tests  = 0;
  int         failed = 0;
  uart_byte_t q[$];
  bit         ov = 1'b0;
  uart_byte_t sent[40];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk({tag, ".out_data"}, 32'(bus.out_data), 32'(q[0]));
    end
    chk({tag, ".full"}, 32'(bus.full), 32'(q.size() == DEPTH));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(ov));
`ifdef UART_RX_FIFO_LEVEL_EN
    chk({tag, ".level"}, 32'(bus.level), 32'(q.size()));
    chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(q.size() >= AFULL));
`endif
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, then check
  task automatic step(input string tag, input bit v, input uart_byte_t d, input bit r, input bit c);
    bit was_full, do_pop, do_push, do_drop;
    bus.in_valid     = v;
    bus.in_data      = d;
    bus.out_ready    = r;
    bus.overflow_clr = c;
    @(posedge clk);
    was_full = (q.size() == DEPTH);
    do_pop   = r && (q.size() != 0);
    do_push  = v && (!was_full || do_pop);
    do_drop  = v && was_full && !do_pop;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(d);
    if (do_drop) ov = 1'b1;
    else if (c) ov = 1'b0;
    #1;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b0;
    bus.overflow_clr = 1'b0;
    check_state(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) step(tag, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic fill(input string tag);
    for (int i = 0; i < 2 * DEPTH && q.size() < DEPTH; i++) step(tag, 1'b1, 8'($urandom), 1'b0, 1'b0);
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_data      = 8'h00;
    bus.out_ready    = 1'b0;
    bus.overflow_clr = 1'b0;

    #12;
    check_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single push, head visible one cycle later
    step("push_a5", 1'b1, 8'hA5, 1'b0, 1'b0);
    chk("push_a5.data", 32'(bus.out_data), 32'h A5);
    chk("push_a5.valid", 32'(bus.out_valid), 32'h1);
    drain("drain_a5");

    // Fill with 0x00..0x0F, overflow on 0xFF, drain in order
    for (int i = 0; i < DEPTH; i++) step("fill_seq", 1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_seq.full", 32'(bus.full), 32'h1);
    step("drop_ff", 1'b1, 8'hFF, 1'b0, 1'b0);
    chk("drop_ff.overflow", 32'(bus.overflow), 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_seq.data", 32'(bus.out_data), 32'(i));
      step("drain_seq", 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_seq.empty", 32'(bus.out_valid), 32'h0);

    // Full FIFO with simultaneous push and pop
    step("clr0", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("fill_pp", 1'b1, 8'(i), 1'b0, 1'b0);
    step("pp_55", 1'b1, 8'h55, 1'b1, 1'b0);
    chk("pp_55.full", 32'(bus.full), 32'h1);
    chk("pp_55.overflow", 32'(bus.overflow), 32'h0);
    chk("pp_55.head", 32'(bus.out_data), 32'h01);
    drain("drain_pp");

    // Streaming: output trails input by one cycle
    for (int i = 0; i < 40; i++) begin
      sent[i] = 8'($urandom);
      step("stream", 1'b1, sent[i], 1'b1, 1'b0);
      chk("stream.lag", 32'(bus.out_data), 32'(sent[i]));
    end
    drain("drain_stream");

    // Sticky overflow: set wins over clear, then clear alone
    fill("fill_ov");
    step("ov_set", 1'b1, 8'h11, 1'b0, 1'b0);
    step("ov_set_clr", 1'b1, 8'h22, 1'b0, 1'b1);
    chk("ov_set_clr.overflow", 32'(bus.overflow), 32'h1);
    step("ov_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ov_clr.overflow", 32'(bus.overflow), 32'h0);
    drain("drain_ov");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 8'($urandom),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
    end
    drain("drain_rand");

    // Asynchronous reset between edges with data held
    for (int i = 0; i < 5; i++) step("load5", 1'b1, 8'($urandom), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    ov = 1'b0;
    check_state("async_rst");
    chk("async_rst.valid", 32'(bus.out_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst", 1'b1, 8'h3C, 1'b0, 1'b0);
    chk("post_rst.data", 32'(bus.out_data), 32'h3C);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
